// File: rtl/microwave_timer_ctrl.sv
// Microwave oven timer: BCD MM:SS keypad entry, 1 s countdown, pause/resume and done handling.
// Optional end-of-cook buzzer enabled by defining DONE_BEEP_EN.
module microwave_timer_ctrl #(
  parameter int DIV       = 100,
  parameter int BEEP_SECS = 3
) (
  input  logic       clk_100Hz,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state,
  output logic       magnetron_on,
  output logic       done,
  output logic       beep
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COOK  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          time_ok;

  // One-second BCD countdown with borrow through all four digits.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign tick    = (state_q == S_COOK) && (presc_q == PW'(DIV - 1));
  assign time_ok = (time_q != 16'h0000) && (time_q[7:4] <= 4'd5);

  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      time_q  <= 16'h0000;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
    end
  end

  // Priority inside each state: stop_clear, then door_open, then start, then tick/key.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!stop_clear && !door_open && start && time_ok) state_d = S_COOK;
        else                                                 state_d = S_IDLE;
      end
      S_COOK: begin
        if (stop_clear || door_open)         state_d = S_PAUSE;
        else if (tick && time_q == 16'h0001) state_d = S_DONE;
        else                                 state_d = S_COOK;
      end
      S_PAUSE: begin
        if (stop_clear)                state_d = S_IDLE;
        else if (!door_open && start)  state_d = S_COOK;
        else                           state_d = S_PAUSE;
      end
      S_DONE: begin
        if (stop_clear || door_open) state_d = S_IDLE;
        else                         state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Time and prescaler updates; the prescaler freezes in PAUSE and restarts on COOK entry.
  always_comb begin
    time_d  = time_q;
    presc_d = presc_q;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_COOK)                       presc_d = '0;
        else if (stop_clear)                         time_d  = 16'h0000;
        else if (key_valid && key_digit <= 4'd9)     time_d  = {time_q[11:0], key_digit};
        else                                         time_d  = time_q;
      end
      S_COOK: begin
        if (state_d == S_PAUSE) begin
          time_d = time_q;
        end else if (tick) begin
          time_d  = bcd_dec(time_q);
          presc_d = '0;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_PAUSE: begin
        if (state_d == S_IDLE)      time_d  = 16'h0000;
        else if (state_d == S_COOK) presc_d = '0;
        else                        time_d  = time_q;
      end
      S_DONE: begin
        if (state_d == S_IDLE) time_d = 16'h0000;
        else                   time_d = time_q;
      end
      default: time_d = 16'h0000;
    endcase
  end

  // Heat is gated by the live door input so opening the door cuts it with no clock delay.
  always_comb begin
    magnetron_on = (state_q == S_COOK) && !door_open;
    done         = (state_q == S_DONE);
  end

  assign state    = state_q;
  assign min_tens = time_q[15:12];
  assign min_ones = time_q[11:8];
  assign sec_tens = time_q[7:4];
  assign sec_ones = time_q[3:0];

`ifdef DONE_BEEP_EN
  localparam int BEEP_CYC = BEEP_SECS * DIV;
  localparam int BW       = $clog2(BEEP_CYC + 1);

  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_q, beep_d;

  // Buzzer starts on the DONE-entry edge and runs BEEP_CYC cycles or until DONE is left.
  always_comb begin
    beep_d     = 1'b0;
    beep_cnt_d = beep_cnt_q;
    if (state_d == S_DONE && state_q != S_DONE) begin
      beep_d     = 1'b1;
      beep_cnt_d = '0;
    end else if (state_d == S_DONE && beep_q) begin
      beep_d     = (beep_cnt_q != BW'(BEEP_CYC - 1));
      beep_cnt_d = beep_cnt_q + BW'(1);
    end else begin
      beep_d     = 1'b0;
      beep_cnt_d = beep_cnt_q;
    end
  end

  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed, table-driven bench for microwave_timer_ctrl at default parameters (DIV=100, BEEP_SECS=3).
module tb_microwave_timer_ctrl;

  logic       clk_100Hz = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start, stop_clear, door_open;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] state;
  logic       magnetron_on, done, beep;
  logic [15:0] time_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       kv;
    logic [3:0] kd;
    logic       st;
    logic       sc;
    logic       dr;
    logic [1:0] es;
    logic [15:0] et;
    logic       em;
  } vec_t;

  vec_t vecs[$];

  microwave_timer_ctrl dut (
    .clk_100Hz   (clk_100Hz),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop_clear  (stop_clear),
    .door_open   (door_open),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .state       (state),
    .magnetron_on(magnetron_on),
    .done        (done),
    .beep        (beep)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  assign time_s = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [1:0] es, input logic [15:0] et, input logic em);
    chk({nm, ".state"}, {14'd0, state}, {14'd0, es});
    chk({nm, ".time"}, time_s, et);
    chk({nm, ".mag"}, {15'd0, magnetron_on}, {15'd0, em});
  endtask

  task automatic step(input logic kv, input logic [3:0] kd, input logic s, input logic sc, input logic dr);
    key_valid  = kv;
    key_digit  = kd;
    start      = s;
    stop_clear = sc;
    door_open  = dr;
    @(posedge clk_100Hz);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop_clear = 1'b0; door_open = 1'b0;
    #1;
    chk_out("reset", 2'd0, 16'h0000, 1'b0);
    chk("reset.done", {15'd0, done}, 16'd0);
    chk("reset.beep", {15'd0, beep}, 16'd0);
    @(posedge clk_100Hz); @(posedge clk_100Hz); #1;
    rst = 1'b0;

    //              kv    kd     st    sc    dr    state  time      mag
    vecs.push_back('{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 2'd0, 16'h0001, 1'b0});
    vecs.push_back('{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 2'd0, 16'h0013, 1'b0});
    vecs.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 2'd0, 16'h0130, 1'b0});
    vecs.push_back('{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0130, 1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 2'd0, 16'h0130, 1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 2'd0, 16'h0007, 1'b0});
    vecs.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 2'd0, 16'h0070, 1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 2'd0, 16'h0070, 1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 2'd0, 16'h0001, 1'b0});
    vecs.push_back('{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 2'd0, 16'h0013, 1'b0});
    vecs.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 2'd0, 16'h0130, 1'b0});
    vecs.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 2'd1, 16'h0130, 1'b1});
    vecs.push_back('{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 2'd1, 16'h0130, 1'b1});

    foreach (vecs[i]) begin
      step(vecs[i].kv, vecs[i].kd, vecs[i].st, vecs[i].sc, vecs[i].dr);
      chk_out($sformatf("vec%0d", i), vecs[i].es, vecs[i].et, vecs[i].em);
    end

    // 01:30 countdown: the last table row was edge 1 after COOK entry
    idle(98);
    chk_out("pre_tick", 2'd1, 16'h0130, 1'b1);
    idle(1);
    chk_out("tick_0129", 2'd1, 16'h0129, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk_out("stop_pause", 2'd2, 16'h0129, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk_out("pause_start_stop", 2'd0, 16'h0000, 1'b0);

    // Door-open pause at 01:00, resume, prescaler restarts
    key(4'd1); key(4'd0); key(4'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk_out("cook_0100", 2'd1, 16'h0100, 1'b1);
    idle(49);
    door_open = 1'b1;
    #1;
    chk("door_mag_immediate", {15'd0, magnetron_on}, 16'd0);
    @(posedge clk_100Hz); #1;
    chk_out("door_pause", 2'd2, 16'h0100, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk_out("pause_hold", 2'd2, 16'h0100, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    chk_out("start_door_open", 2'd2, 16'h0100, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk_out("resume", 2'd1, 16'h0100, 1'b1);
    idle(99);
    chk_out("resume_pre_tick", 2'd1, 16'h0100, 1'b1);
    idle(1);
    chk_out("tick_0059", 2'd1, 16'h0059, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk_out("clear_0059", 2'd0, 16'h0000, 1'b0);

    // Minute-tens borrow 10:00 -> 09:59
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(100);
    chk_out("tick_0959", 2'd1, 16'h0959, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk_out("clear_0959", 2'd0, 16'h0000, 1'b0);

    // 00:01 -> DONE exactly 100 cycles after start
    key(4'd0); key(4'd1);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk_out("cook_0001", 2'd1, 16'h0001, 1'b1);
    idle(99);
    chk_out("pre_done", 2'd1, 16'h0001, 1'b1);
    chk("pre_done.done", {15'd0, done}, 16'd0);
    idle(1);
    chk_out("done_entry", 2'd3, 16'h0000, 1'b0);
    chk("done_entry.done", {15'd0, done}, 16'd1);
`ifdef DONE_BEEP_EN
    chk("beep_start", {15'd0, beep}, 16'd1);
    idle(299);
    chk("beep_last", {15'd0, beep}, 16'd1);
    idle(1);
    chk("beep_end", {15'd0, beep}, 16'd0);
    chk_out("done_hold", 2'd3, 16'h0000, 1'b0);
`else
    chk("beep_off", {15'd0, beep}, 16'd0);
    idle(10);
    chk("beep_off_later", {15'd0, beep}, 16'd0);
`endif
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk_out("done_door_idle", 2'd0, 16'h0000, 1'b0);
    chk("done_door_idle.done", {15'd0, done}, 16'd0);

    // Asynchronous reset in the middle of cooking at 05:43
    key(4'd5); key(4'd4); key(4'd3);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk_out("cook_0543", 2'd1, 16'h0543, 1'b1);
    idle(10);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 2'd0, 16'h0000, 1'b0);
    @(posedge clk_100Hz); #1;
    rst = 1'b0;
    idle(3);
    chk_out("after_rst", 2'd0, 16'h0000, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk_out("start_zero_time", 2'd0, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/microwave_timer_ctrl.md
MICROWAVE_TIMER_CTRL -- requirements
Module: microwave_timer_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 100: number of clk_100Hz cycles per 1 s tick.
REQ-002 The block SHALL have parameter BEEP_SECS, default 3: end-of-cook beep duration in seconds.
REQ-003 The block SHALL have port clk_100Hz, input, 1 bit: single system clock, 100 Hz.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port key_valid, input, 1 bit: one-cycle keypad strobe.
REQ-006 The block SHALL have port key_digit, input, 4 bits: keypad value qualified by key_valid.
REQ-007 The block SHALL have port start, input, 1 bit: start/resume request, level sampled each cycle.
REQ-008 The block SHALL have port stop_clear, input, 1 bit: pause/clear request.
REQ-009 The block SHALL have port door_open, input, 1 bit: door sensor, 1 = open.
REQ-010 The block SHALL have ports min_tens, min_ones, sec_tens, sec_ones, output, 4 bits each: BCD time MM:SS.
REQ-011 The block SHALL have port state, output, 2 bits: 0=IDLE, 1=COOK, 2=PAUSE, 3=DONE.
REQ-012 The block SHALL have port magnetron_on, output, 1 bit: heater enable.
REQ-013 The block SHALL have port done, output, 1 bit: high while state is DONE.
REQ-014 The block SHALL have port beep, output, 1 bit: buzzer drive.

Function
REQ-015 Internal prescaler SHALL count 0..DIV-1 only in COOK, assert tick when it equals DIV-1, and wrap to 0; it SHALL clear on every entry to COOK.
REQ-016 In IDLE, key_valid with key_digit<=9 SHALL shift time left one digit (min_tens<=min_ones<=sec_tens<=sec_ones<=key_digit) on that edge; key_digit>9 SHALL be ignored; key_valid outside IDLE SHALL be ignored.
REQ-017 IDLE->COOK SHALL occur when start=1, door_open=0, stop_clear=0, time!=00:00 and sec_tens<=5; otherwise start SHALL be ignored.
REQ-018 In COOK each tick SHALL decrement time by 1 s in BCD: sec_ones 0->9 with borrow, sec_tens 0->5 with borrow, min_ones 0->9 with borrow, min_tens decrements.
REQ-019 First decrement SHALL occur DIV cycles after the COOK-entry edge, then every DIV cycles.
REQ-020 A tick with time=00:01 SHALL set time to 00:00 and state to DONE on the same edge.
REQ-021 COOK->PAUSE SHALL occur on door_open=1 or stop_clear=1; time and prescaler SHALL hold.
REQ-022 PAUSE->COOK SHALL occur on start=1 with door_open=0 and stop_clear=0; PAUSE->IDLE with time cleared to 00:00 SHALL occur on stop_clear=1.
REQ-023 DONE->IDLE with time cleared SHALL occur on stop_clear=1 or door_open=1.
REQ-024 Simultaneous events SHALL resolve as stop_clear > door_open > start > tick/key.
REQ-025 magnetron_on SHALL equal (state==COOK) AND NOT door_open, combinationally, so an open door removes heat with zero latency.
REQ-026 done SHALL be (state==DONE), registered state decode.

Reset
REQ-027 rst=1 SHALL asynchronously force state=IDLE, time=00:00, prescaler=0, beep counter=0; magnetron_on=0, done=0, beep=0 while rst is held.
REQ-028 rst asserted mid-COOK SHALL abort cooking immediately; after release the block SHALL wait in IDLE for new entry.

Configuration
REQ-029 With macro DONE_BEEP_EN defined, beep SHALL go high on the DONE-entry edge and stay high for BEEP_SECS*DIV cycles or until DONE is left, whichever is first.
REQ-030 Without DONE_BEEP_EN, beep SHALL be tied to 0 and no beep counter SHALL be synthesized; all other behaviour is unchanged.

Verification
REQ-031 Keys 1,3,0 then start (door closed) -> time 01:30, state=COOK, magnetron_on=1; after 100 cycles time=01:29.
REQ-032 Enter 00:01, start -> DONE exactly 100 cycles later, time=00:00, done=1; with DONE_BEEP_EN, beep=1 for 300 cycles.
REQ-033 Cooking at 01:00, door_open=1 -> magnetron_on=0 same cycle, state=PAUSE; close door, start -> COOK; next tick gives 00:59.
REQ-034 start and stop_clear both high in PAUSE -> state=IDLE, time=00:00.
REQ-035 Enter 0,0,7,0 (sec_tens=7), start -> remains IDLE; time 00:00, start -> remains IDLE.
REQ-036 rst pulse mid-COOK at 05:43 -> state=IDLE, time=00:00, magnetron_on=0 asynchronously.
